// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants (package mips_pkg).
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } redir_sel_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // J/JAL target: keep the 256 MB region of the delay-free successor PC.
  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: imem word, hazard/controller inputs and IF/ID outputs.
// IF_PERF_COUNTERS_EN adds FetchCount/FlushCount.
interface if_stage_if;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Halt;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic        JumpReg;
  logic [31:0] JumpRegAddr;
  logic [31:0] PC;
  logic [31:0] Instruction_ID;
  logic [31:0] PCPlus4_ID;
  logic        Valid_ID;
  logic        Misaligned;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] FetchCount;
  logic [31:0] FlushCount;
`endif

  modport master (
    output Instruction, Stall, Halt, Branch, BranchTarget, Jump, JumpReg, JumpRegAddr,
    input  PC, Instruction_ID, PCPlus4_ID, Valid_ID, Misaligned
`ifdef IF_PERF_COUNTERS_EN
    , input FetchCount, FlushCount
`endif
  );

  modport slave (
    input  Instruction, Stall, Halt, Branch, BranchTarget, Jump, JumpReg, JumpRegAddr,
    output PC, Instruction_ID, PCPlus4_ID, Valid_ID, Misaligned
`ifdef IF_PERF_COUNTERS_EN
    , output FetchCount, FlushCount
`endif
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: load, hold, flush-to-bubble and valid-kill.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic        kill_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // Flush makes the slot look exactly like the post-reset bubble.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_i) begin
      instr_d    = NOP_WORD;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (kill_i) begin
      valid_d = 1'b0;
    end else if (!hold_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, redirect mux, BOOT/RUN/HALT FSM, IF/ID register.
// Define IF_PERF_COUNTERS_EN to add FetchCount/FlushCount.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic  Clk,
  input  logic  Reset,
  if_stage_if.slave bus
);

  state_e      state_q, state_d;
  redir_sel_e  sel;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        mis_q, mis_d;
  logic        ifid_hold, ifid_flush, ifid_kill;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (bus.JumpReg)     sel = SEL_JR;
    else if (bus.Jump)   sel = SEL_J;
    else if (bus.Branch) sel = SEL_BR;
    else                 sel = SEL_SEQ;
  end

  always_comb begin
    case (sel)
      SEL_JR:  target = {bus.JumpRegAddr[31:2], 2'b00};
      SEL_J:   target = jump_target(bus.PCPlus4_ID[31:28], bus.Instruction_ID[25:0]);
      SEL_BR:  target = bus.BranchTarget;
      default: target = pc_plus4;
    endcase
  end

  // Halt is examined before Stall so a stalled pipe can still be frozen.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mis_d      = mis_q;
    ifid_hold  = 1'b1;
    ifid_flush = 1'b0;
    ifid_kill  = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.Halt) begin
          state_d   = HALT;
          ifid_kill = 1'b1;
        end else if (!bus.Stall) begin
          pc_d = target;
          if (sel == SEL_SEQ) begin
            ifid_hold = 1'b0;
          end else begin
            ifid_flush = 1'b1;
            if (sel == SEL_JR && bus.JumpRegAddr[1:0] != 2'b00) mis_d = 1'b1;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .hold_i     (ifid_hold),
    .flush_i    (ifid_flush),
    .kill_i     (ifid_kill),
    .instr_i    (bus.Instruction),
    .pc_plus4_i (pc_plus4),
    .instr_o    (bus.Instruction_ID),
    .pc_plus4_o (bus.PCPlus4_ID),
    .valid_o    (bus.Valid_ID)
  );

  assign bus.PC         = pc_q;
  assign bus.Misaligned = mis_q;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  // A released hold is exactly a valid IF/ID load; a flush is a taken redirect.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ifid_hold) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (ifid_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.FetchCount = fetch_cnt_q;
  assign bus.FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios then randomized traffic.
`timescale 1ns/1ps
module tb_if_stage;

  logic Clk = 1'b0;
  logic Reset;
  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0040: return 32'h0800_0010;
      default:       return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endcase
  endfunction

  assign bus.Instruction = imem(bus.PC);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    logic        mis;
    logic [31:0] fc;
    logic [31:0] flc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state
  logic [31:0] m_pc, m_ins, m_p4, m_fc, m_flc;
  logic        m_v, m_mis, m_boot, m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  task automatic step(input logic rst, input logic stall, input logic halt,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic jr, input logic [31:0] jra);
    exp_t e;
    logic [31:0] nxt;
    Reset            = rst;
    bus.Stall        = stall;
    bus.Halt         = halt;
    bus.Branch       = br;
    bus.BranchTarget = bt;
    bus.Jump         = j;
    bus.JumpReg      = jr;
    bus.JumpRegAddr  = jra;
    if (rst) begin
      m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_v = 0; m_mis = 0;
      m_boot = 1; m_halt = 0; m_fc = 0; m_flc = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      // frozen until reset
    end else if (halt) begin
      m_halt = 1;
      m_v    = 0;
    end else if (!stall) begin
      if (jr || j || br) begin
        if (jr) begin
          nxt = jra & 32'hFFFF_FFFC;
          if (jra % 4 != 0) m_mis = 1;
        end else if (j) begin
          nxt = (m_p4 & 32'hF000_0000) | ((m_ins & 32'h03FF_FFFF) * 4);
        end else begin
          nxt = bt;
        end
        m_pc  = nxt;
        m_ins = 32'h0;
        m_p4  = 32'h0;
        m_v   = 0;
        m_flc = m_flc + 1;
      end else begin
        m_ins = imem(m_pc);
        m_p4  = m_pc + 4;
        m_v   = 1;
        m_pc  = m_pc + 4;
        m_fc  = m_fc + 1;
      end
    end
    e.pc = m_pc; e.ins = m_ins; e.p4 = m_p4; e.v = m_v; e.mis = m_mis;
    e.fc = m_fc; e.flc = m_flc;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  // Monitor: one registered result per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("PC", bus.PC, e.pc);
        chk("Instruction_ID", bus.Instruction_ID, e.ins);
        chk("Valid_ID", {31'b0, bus.Valid_ID}, {31'b0, e.v});
        chk("Misaligned", {31'b0, bus.Misaligned}, {31'b0, e.mis});
        if (e.v) chk("PCPlus4_ID", bus.PCPlus4_ID, e.p4);
`ifdef IF_PERF_COUNTERS_EN
        chk("FetchCount", bus.FetchCount, e.fc);
        chk("FlushCount", bus.FlushCount, e.flc);
`endif
      end
    end
  end

  initial begin
    logic rst, stall, halt, br, j, jr;
    logic [31:0] bt, jra;

    // Reset, boot bubble and free-running fetch
    step(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    repeat (4) idle();
    // Taken branch, then fetch resumes past the target
    step(0, 0, 0, 1, 32'h0000_0040, 0, 0, 32'h0);
    idle();
    // Jump and misaligned JumpReg together: JumpReg wins
    step(0, 0, 0, 0, 32'h0, 1, 1, 32'h0000_0102);
    repeat (2) idle();
    // Branch held off by a three-cycle stall
    repeat (3) step(0, 1, 0, 1, 32'h0000_0200, 0, 0, 32'h0);
    step(0, 0, 0, 1, 32'h0000_0200, 0, 0, 32'h0);
    idle();
    // Halt together with Stall at PC 0x20, then frozen, then reset
    step(0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0020);
    step(0, 1, 1, 0, 32'h0, 0, 0, 32'h0);
    repeat (10) step(0, 0, 0, 1, 32'h0000_0300, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) idle();
    // PC wrap from FFFF_FFFC to 0
    step(0, 0, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFF8);
    repeat (3) idle();

    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 3) == 0);
      halt  = ($urandom_range(0, 99) < 2);
      br    = ($urandom_range(0, 4) == 0);
      j     = ($urandom_range(0, 7) == 0);
      jr    = ($urandom_range(0, 7) == 0);
      bt    = $urandom & 32'hFFFF_FFFC;
      jra   = $urandom;
      if ($urandom_range(0, 3) != 0) jra = jra & 32'hFFFF_FFFC;
      step(rst, stall, halt, br, bt, j, jr, jra);
    end

    idle();
    #5;
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
